// File: rtl/scl180_mon_pkg.sv
// Shared types and helpers for the spare-cell LO monitor.
package scl180_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MONITOR = 2'd2,
        ST_FAULT   = 2'd3
    } mon_state_e;

    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned FILT_W     = 8;
    localparam int unsigned SETTLE_W   = 8;

    // a + b clamped to lim; 33-bit sum so the clamp never sees a wrapped value
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

endpackage

// File: rtl/scl180_sync_filter_bit.sv
// One monitored LO bit: synchroniser, rising-edge detect and stuck-high filter.
module scl180_sync_filter_bit
    import scl180_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic lo,
    input  logic active,
    output logic rise_pulse,
    output logic fault_set
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic [FILT_W-1:0]      filt_q;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchroniser plus a delayed copy for edge detection; runs in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lo};
            sync_d <= sync;
        end
    end

    // Consecutive-high counter; held at zero whenever monitoring is off or cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
        end else if (!active || !sync) begin
            filt_q <= '0;
        end else begin
            filt_q <= FILT_W'(sat_add(32'(filt_q), 32'd1, 32'(FILT_CYCLES)));
        end
    end

    assign rise_pulse = active && sync && !sync_d;
    assign fault_set  = active && sync && (filt_q == FILT_W'(FILT_CYCLES - 1));

endmodule

// File: rtl/scl180_sparecell_lo_monitor.sv
// Spare-cell LO tie monitor: per-cell stuck-high detection, glitch counting
// and a summary fault flag for the housekeeping status path.
module scl180_sparecell_lo_monitor
    import scl180_mon_pkg::*;
#(
    parameter int unsigned N_CELLS       = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILT_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [N_CELLS-1:0] lo_i,
    input  logic               enable_i,
    input  logic               clear_i,
    output logic               fault_o,
    output logic [N_CELLS-1:0] fault_mask_o,
    output logic [CNT_W-1:0]   glitch_count_o,
    output logic [1:0]         state_o
);

    localparam int unsigned POP_W   = $clog2(N_CELLS + 1);
    localparam logic [31:0] CNT_MAX = 32'((33'd1 << CNT_W) - 33'd1);

    mon_state_e            state_q;
    logic [SETTLE_W-1:0]   settle_q;
    logic                  mon_active;
    logic [N_CELLS-1:0]    rise;
    logic [N_CELLS-1:0]    fault_set;
    logic [POP_W-1:0]      rise_cnt;

    // A clear in the same cycle as an event discards that event
    assign mon_active = ((state_q == ST_MONITOR) || (state_q == ST_FAULT)) && !clear_i;
    assign state_o    = state_q;

    for (genvar i = 0; i < int'(N_CELLS); i++) begin : g_cell
        scl180_sync_filter_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES)
        ) u_cell (
            .clk        (wb_clk_i),
            .rst        (wb_rst_i),
            .lo         (lo_i[i]),
            .active     (mon_active),
            .rise_pulse (rise[i]),
            .fault_set  (fault_set[i])
        );
    end

    always_comb begin
        rise_cnt = '0;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            rise_cnt = rise_cnt + POP_W'(rise[i]);
        end
    end

    // Sticky flags, saturating glitch count and summary flag
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            fault_mask_o   <= '0;
            glitch_count_o <= '0;
            fault_o        <= 1'b0;
        end else begin
            fault_o <= |fault_mask_o;
            if (clear_i) begin
                fault_mask_o   <= '0;
                glitch_count_o <= '0;
            end else begin
                fault_mask_o   <= fault_mask_o | fault_set;
                glitch_count_o <= CNT_W'(sat_add(32'(glitch_count_o), 32'(rise_cnt), CNT_MAX));
            end
        end
    end

    // Control FSM; clear restarts the settle window when still enabled
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
        end else if (clear_i) begin
            if (enable_i) begin
                state_q  <= ST_SETTLE;
                settle_q <= SETTLE_W'(SETTLE_CYCLES - 1);
            end else begin
                state_q  <= ST_IDLE;
            end
        end else if (!enable_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q  <= ST_SETTLE;
                    settle_q <= SETTLE_W'(SETTLE_CYCLES - 1);
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= ST_MONITOR;
                    end else begin
                        settle_q <= settle_q - SETTLE_W'(1);
                    end
                end
                ST_MONITOR: begin
                    if (|fault_mask_o) begin
                        state_q <= ST_FAULT;
                    end
                end
                default: state_q <= ST_FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_scl180_sparecell_lo_monitor.sv
// Directed and randomized checks of the spare-cell LO monitor against a
// behavioural model built from delay lines, run lengths and clamped sums.
module tb_scl180_sparecell_lo_monitor;

    localparam int N      = 4;
    localparam int SYNC   = 2;
    localparam int FILT   = 4;
    localparam int SETTLE = 16;
    localparam int CW     = 8;
    localparam int CMAX   = 255;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic [N-1:0]  lo_i     = '0;
    logic          enable_i = 1'b0;
    logic          clear_i  = 1'b0;
    logic          fault_o;
    logic [N-1:0]  fault_mask_o;
    logic [CW-1:0] glitch_count_o;
    logic [1:0]    state_o;

    int n_cmp = 0;
    int n_err = 0;

    scl180_sparecell_lo_monitor #(
        .N_CELLS(N), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT),
        .SETTLE_CYCLES(SETTLE), .CNT_W(CW)
    ) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .lo_i           (lo_i),
        .enable_i       (enable_i),
        .clear_i        (clear_i),
        .fault_o        (fault_o),
        .fault_mask_o   (fault_mask_o),
        .glitch_count_o (glitch_count_o),
        .state_o        (state_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- behavioural model ----------------
    int           m_state;     // 0 idle, 1 settle, 2 monitor, 3 fault
    int           m_left;      // settle cycles still to spend
    int           m_cnt;
    logic [N-1:0] m_mask;
    logic         m_fault;
    int           m_run [N];   // consecutive synced-high cycles seen while monitoring
    logic [N-1:0] m_hist [$];  // raw samples, newest first
    logic [N-1:0] seen, prev, old_mask;
    bit           mon;
    int           rises;

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            m_state = 0; m_left = 0; m_cnt = 0; m_mask = '0; m_fault = 1'b0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_hist.delete();
            for (int i = 0; i <= SYNC; i++) m_hist.push_back('0);
        end else begin
            seen     = m_hist[SYNC-1];
            prev     = m_hist[SYNC];
            old_mask = m_mask;
            mon      = (m_state >= 2) && !clear_i;
            rises    = 0;
            for (int i = 0; i < N; i++) begin
                if (seen[i] && !prev[i]) rises++;
                m_run[i] = (mon && seen[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == FILT) m_mask[i] = 1'b1;
            end
            if (clear_i) begin
                m_mask = '0;
                m_cnt  = 0;
            end else if (mon) begin
                m_cnt = (m_cnt + rises > CMAX) ? CMAX : m_cnt + rises;
            end
            m_fault = |old_mask;
            if (clear_i) begin
                if (enable_i) begin m_state = 1; m_left = SETTLE; end
                else m_state = 0;
            end else if (!enable_i) begin
                m_state = 0;
            end else if (m_state == 0) begin
                m_state = 1; m_left = SETTLE;
            end else if (m_state == 1) begin
                m_left--;
                if (m_left == 0) m_state = 2;
            end else if (m_state == 2 && old_mask != '0) begin
                m_state = 3;
            end
            m_hist.push_front(lo_i);
            void'(m_hist.pop_back());
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"}, 32'(state_o), 32'(m_state));
        chk({tag, ".fault"}, 32'(fault_o), 32'(m_fault));
        chk({tag, ".mask"},  32'(fault_mask_o), 32'(m_mask));
        chk({tag, ".count"}, 32'(glitch_count_o), 32'(m_cnt));
    endtask

    task automatic step(input int n, input string tag);
        repeat (n) begin
            @(negedge wb_clk_i);
            check_model(tag);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset
        repeat (3) @(negedge wb_clk_i);
        chk("rst.state", 32'(state_o), 0);
        chk("rst.mask",  32'(fault_mask_o), 0);
        chk("rst.count", 32'(glitch_count_o), 0);
        chk("rst.fault", 32'(fault_o), 0);
        wb_rst_i = 1'b0;
        enable_i = 1'b1;

        // quiet inputs: settle then monitor
        step(1, "quiet");
        chk("quiet.settle", 32'(state_o), 1);
        step(15, "quiet");
        chk("quiet.still_settle", 32'(state_o), 1);
        step(1, "quiet");
        chk("quiet.monitor", 32'(state_o), 2);
        step(83, "quiet");
        chk("quiet.count", 32'(glitch_count_o), 0);

        // stuck-high on cell 2
        lo_i = 4'b0100;
        step(5, "stuck");
        chk("stuck.early_mask", 32'(fault_mask_o), 0);
        step(1, "stuck");
        chk("stuck.mask", 32'(fault_mask_o), 32'h4);
        chk("stuck.fault_lag", 32'(fault_o), 0);
        step(1, "stuck");
        chk("stuck.fault", 32'(fault_o), 1);
        chk("stuck.state", 32'(state_o), 3);
        chk("stuck.count", 32'(glitch_count_o), 1);
        lo_i = '0;
        step(4, "stuck");
        clear_i = 1'b1;
        step(1, "clr1");
        clear_i = 1'b0;
        chk("clr1.state", 32'(state_o), 1);
        step(16, "clr1");

        // short pulses: three on cell 0, one simultaneous on cells 1 and 3
        for (int p = 0; p < 3; p++) begin
            lo_i = 4'b0001; step(2, "pulse");
            lo_i = 4'b0000; step(2, "pulse");
        end
        lo_i = 4'b1010; step(2, "pulse");
        lo_i = 4'b0000; step(4, "pulse");
        chk("pulse.count", 32'(glitch_count_o), 5);
        chk("pulse.mask",  32'(fault_mask_o), 0);
        chk("pulse.state", 32'(state_o), 2);

        // activity during settle is ignored
        clear_i = 1'b1;
        step(1, "settle_ign");
        clear_i = 1'b0;
        lo_i = 4'hF; step(6, "settle_ign");
        lo_i = 4'h0; step(10, "settle_ign");
        chk("settle_ign.state", 32'(state_o), 2);
        chk("settle_ign.count", 32'(glitch_count_o), 0);
        chk("settle_ign.mask",  32'(fault_mask_o), 0);

        // counter saturation
        for (int p = 0; p < 300; p++) begin
            lo_i = 4'b0001; step(1, "sat");
            lo_i = 4'b0000; step(1, "sat");
        end
        step(4, "sat");
        chk("sat.count", 32'(glitch_count_o), CMAX);

        // randomized traffic with occasional clears and enable drops
        clear_i = 1'b1;
        step(1, "rand");
        clear_i = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) lo_i[b] = ~lo_i[b];
            clear_i  = ($urandom_range(0, 79) == 0);
            enable_i = ($urandom_range(0, 149) != 0);
            step(1, "rand");
        end
        clear_i = 1'b0; enable_i = 1'b1; lo_i = '0;
        step(4, "rand");

        // clear coinciding with a filter completion
        clear_i = 1'b1; step(1, "clrwin"); clear_i = 1'b0;
        step(16, "clrwin");
        lo_i = 4'b0001;
        step(6, "clrwin");
        chk("clrwin.mask0", 32'(fault_mask_o), 32'h1);
        step(1, "clrwin");
        chk("clrwin.fault_state", 32'(state_o), 3);
        lo_i = 4'b0010;
        step(5, "clrwin");
        clear_i = 1'b1;
        step(1, "clrwin");
        clear_i = 1'b0;
        chk("clrwin.mask", 32'(fault_mask_o), 0);
        chk("clrwin.count", 32'(glitch_count_o), 0);
        chk("clrwin.state", 32'(state_o), 1);
        step(16, "clrwin");
        chk("clrwin.monitor", 32'(state_o), 2);
        step(3, "clrwin");
        chk("clrwin.not_yet", 32'(fault_mask_o), 0);
        step(1, "clrwin");
        chk("clrwin.refault", 32'(fault_mask_o), 32'h2);

        // async reset mid-monitor
        lo_i = '0;
        step(4, "arst");
        clear_i = 1'b1; step(1, "arst"); clear_i = 1'b0;
        step(16, "arst");
        for (int p = 0; p < 6; p++) begin
            lo_i = 4'b1000; step(1, "arst");
            lo_i = 4'b0000; step(1, "arst");
        end
        lo_i = 4'b0100;
        step(6, "arst");
        chk("arst.pre_count", 32'(glitch_count_o), 7);
        chk("arst.pre_mask",  32'(fault_mask_o), 32'h4);
        chk("arst.pre_state", 32'(state_o), 2);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("arst.state", 32'(state_o), 0);
        chk("arst.mask",  32'(fault_mask_o), 0);
        chk("arst.count", 32'(glitch_count_o), 0);
        chk("arst.fault", 32'(fault_o), 0);
        @(negedge wb_clk_i);
        check_model("arst.hold");
        wb_rst_i = 1'b0;
        lo_i     = '0;
        step(1, "arst");
        chk("arst.resettle", 32'(state_o), 1);
        step(3, "arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scl180_sparecell_lo_monitor.md
Name: scl180_sparecell_lo_monitor

Overview:
Observes the constant-low tie outputs (LO) of N spare-cell macros and confirms each one actually stays low in silicon. Each LO input is synchronised and glitch-filtered. The block records sticky per-cell faults and a saturating rising-edge (glitch) count, and raises one summary fault flag for the housekeeping/GPIO status path. It sits in the always-on clock domain beside the spare-cell instances.

Parameters:
N_CELLS, 4, number of spare-cell LO outputs monitored.
SYNC_STAGES, 2, flops per input synchroniser (minimum 2).
FILT_CYCLES, 4, consecutive synced-high cycles that declare a stuck-high fault (1..255).
SETTLE_CYCLES, 16, cycles ignored after enable rises (1..255).
CNT_W, 8, glitch counter width.

Ports:
wb_clk_i  input  1  system clock.
wb_rst_i  input  1  reset, asynchronous assert, active-high.
lo_i  input  N_CELLS  raw LO outputs from the spare-cell macros (asynchronous).
enable_i  input  1  monitoring enable (level).
clear_i  input  1  one-cycle pulse; clears sticky faults and the counter.
fault_o  output  1  OR of fault_mask_o, registered.
fault_mask_o  output  N_CELLS  sticky per-cell stuck-high flags.
glitch_count_o  output  CNT_W  saturating count of synced 0->1 transitions, summed over all cells.
state_o  output  2  current FSM state encoding, for debug.

Behaviour:
- Reset (async assert, sync release by the flops): all synchroniser flops, filter counters, fault_mask_o, fault_o and glitch_count_o go to 0; FSM goes to IDLE (2'd0).
- Synchroniser: SYNC_STAGES flops per bit, reset to 0. Total input-to-sync latency is SYNC_STAGES cycles. A registered copy sync_d provides edge detection.
- FSM states: IDLE=0, SETTLE=1, MONITOR=2, FAULT=3.
  - IDLE -> SETTLE when enable_i=1. The settle counter loads SETTLE_CYCLES-1.
  - SETTLE: counts down to 0, then goes to MONITOR. No filter or edge updates happen here; filter counters are held at 0.
  - MONITOR -> FAULT the cycle after any fault_mask bit becomes 1.
  - FAULT: monitoring continues, so more cells may fault and the count keeps running. The block stays in FAULT until clear_i.
  - From any non-IDLE state, enable_i=0 -> IDLE the next cycle. Sticky flags and the count are retained. Filter counters reset to 0.
- Filter, per cell, in MONITOR/FAULT only:
  - sync=1 increments filt[i], saturating at FILT_CYCLES.
  - sync=0 sets filt[i] to 0.
  - fault_mask_o[i] sets on the cycle filt[i] reaches FILT_CYCLES. Detection latency from a sustained raw high is SYNC_STAGES+FILT_CYCLES cycles.
- Glitch count, in MONITOR/FAULT only:
  - Each cycle, add popcount(sync & ~sync_d) to the count, saturating at 2^CNT_W-1. Multiple simultaneous edges add together.
  - A pulse shorter than one clock may be missed; this is accepted.
- fault_o = |fault_mask_o, registered. It lags the mask by one cycle.
- clear_i:
  - Clears fault_mask_o, glitch_count_o and filter counters.
  - If enable_i=1, the FSM goes to SETTLE (settle reloaded); otherwise it goes to IDLE.
  - If a new event occurs in the same cycle as clear_i, clear wins: that cycle's edges and fault sets are discarded.
- enable_i rising while clear_i=1: the FSM goes to SETTLE once.
- Reset mid-SETTLE or mid-MONITOR: immediate return to IDLE with all state zeroed.

Decomposition:
- Shared package scl180_mon_pkg holds:
  - the state enum (IDLE/SETTLE/MONITOR/FAULT with fixed encodings);
  - a default-width localparam for the counters;
  - a saturating-increment function.
- One natural sub-module, scl180_sync_filter_bit, instantiated N_CELLS times. It contains one cell's synchroniser, edge detect and filter counter, and outputs rise_pulse and fault_set.
- The top level holds the FSM, popcount, counter and sticky flags.

Test Plan:
- Reset, then enable_i=1 with lo_i=0 for 100 cycles -> state goes 0→1 then reaches 2 after 16 cycles; all outputs stay 0.
- In MONITOR, hold lo_i[2]=1 -> fault_mask_o=4'b0100 exactly 6 cycles after the raw rise; fault_o=1 one cycle later; state=3; glitch_count_o=1.
- In MONITOR, apply three 2-cycle pulses on lo_i[0] plus one simultaneous 2-cycle pulse on lo_i[1]&lo_i[3] -> glitch_count_o=5; fault_mask_o=0; state stays 2.
- Drive lo_i high during SETTLE, then drop it before MONITOR -> count=0 and mask=0. Separately, toggle lo_i[0] 300 times in MONITOR with CNT_W=8 -> count saturates at 255.
- In FAULT with mask=4'b0001, pulse clear_i in the same cycle lo_i[1] completes its filter -> mask=0, count=0, state=1; lo_i[1] still high re-faults 4 cycles after MONITOR entry.
- Assert wb_rst_i asynchronously mid-MONITOR with count=7 and mask≠0 -> all outputs read 0 before the next clock edge; deassert with enable_i=1 -> state goes to SETTLE.
